imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter SIZE, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have localparam AW = $clog2(SIZE), meaning the word-address width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port in_rst, input, 1, the asynchronous active-high reset.
REQ-005 SHALL have port i_start, input, 1, a load-request pulse, sampled only in IDLE.
REQ-006 SHALL have port i_byte_valid, input, 1, meaning a byte is offered.
REQ-007 SHALL have port i_byte, input, 8, the byte-stream data.
REQ-008 SHALL have port o_byte_ready, output, 1, meaning the loader accepts the byte; transfer = valid && ready.
REQ-009 SHALL have port o_we, output, 1, the instruction-memory write strobe.
REQ-010 SHALL have port o_waddr, output, AW, the word address to write.
REQ-011 SHALL have port o_wdata, output, 32, the instruction word to write.
REQ-012 SHALL have port o_busy, output, 1, which holds the CPU in reset while a load is in progress.
REQ-013 SHALL have port o_done, output, 1, a one-cycle load-finished pulse.
REQ-014 SHALL have port o_err, output, 1, a sticky error flag, cleared by the next accepted i_start.

Function
REQ-015 Stream format SHALL be: 2-byte word count N (little-endian), then 4*N data bytes forming little-endian words (first byte = bits 7:0).
REQ-016 The FSM SHALL have states IDLE, LEN, DATA, CSUM (CSUM is present only with the macro), and FIN.
REQ-017 IDLE SHALL go to LEN on i_start; o_busy is 0 only in IDLE.
REQ-018 o_byte_ready SHALL be 1 in LEN, DATA and CSUM, and 0 in IDLE and FIN.
REQ-019 LEN SHALL go to DATA after 2 bytes are accepted.
  - If N = 0, LEN SHALL go directly to CSUM/FIN.
  - If N > SIZE, LEN SHALL set o_err and go to FIN; no writes occur.
REQ-020 DATA SHALL pack each group of 4 accepted bytes into a word.
  - o_we SHALL assert for exactly one cycle, in the cycle after the 4th byte handshake.
  - o_waddr SHALL be 0 for the first word and increment by 1 per word.
  - o_wdata SHALL hold the packed word while o_we is high.
REQ-021 Byte acceptance SHALL continue without a stall in the cycle o_we is high (full throughput of 1 byte per cycle).
REQ-022 After the N-th word is written, DATA SHALL go to CSUM (macro on) or FIN (macro off).
REQ-023 FIN SHALL pulse o_done for one cycle and return to IDLE in the next cycle.
REQ-024 i_start SHALL be ignored outside IDLE; an i_start accepted in IDLE SHALL clear o_err.
REQ-025 o_waddr SHALL never wrap: N <= SIZE guarantees the last address is SIZE-1.
REQ-026 o_we SHALL be registered; o_waddr and o_wdata SHALL be stable while o_we = 1.

Reset
REQ-027 in_rst high SHALL immediately force the following, independent of i_clk:
  - state IDLE;
  - o_we, o_busy, o_done, o_err and o_byte_ready = 0;
  - o_waddr and o_wdata = 0;
  - byte counter, word counter and checksum = 0.
REQ-028 A reset mid-load SHALL abandon the load; words already written are not rolled back.

Configuration
REQ-029 When macro IMEM_LOADER_CHECKSUM_EN is defined, the checksum feature SHALL be compiled in:
  - a running XOR of all data bytes is kept;
  - CSUM accepts 1 trailing byte;
  - a mismatch sets o_err;
  - CSUM then goes to FIN.
REQ-030 When IMEM_LOADER_CHECKSUM_EN is undefined, no CSUM state and no checksum register SHALL exist, and DATA goes to FIN directly.

Structure
REQ-031 Package imem_loader_pkg SHALL hold:
  - the state enum typedef;
  - LEN_BYTES = 2;
  - BYTES_PER_WORD = 4;
  - the 16-bit count typedef.
REQ-032 Sub-module imem_byte_packer SHALL handle little-endian 4-byte assembly and byte-lane counting, producing a word_valid pulse.

Verification
REQ-033 Basic load: start, then bytes 02 00 13 05 10 00 93 05 20 00 -> two writes, one per cycle after each word completes: addr0 = 0x00100513, addr1 = 0x00200593; then o_done pulse; o_err = 0.
REQ-034 Backpressure gaps: the same stream with i_byte_valid toggling every other cycle -> identical writes, and no write before the 4th byte of each word.
REQ-035 Zero count: N = 00 00 -> no o_we; o_done pulses within 2 cycles (macro off), or after 1 checksum byte 0x00 (macro on).
REQ-036 Oversize: SIZE = 1024 and N = 0x0401 -> o_err = 1, o_done pulses, no o_we; the next i_start clears o_err.
REQ-037 Reset mid-load: assert in_rst after 5 data bytes -> all outputs 0 at once; a fresh load afterwards starts at addr 0.
REQ-038 Checksum (macro on): with 1 word 0x00100513, trailer 0x06 -> o_err = 0; trailer 0x07 -> o_err = 1, and the word is still written.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_FIN  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_FIN  = 3'd4
  } state_t;
`endif

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [15:0] count_t;

  // Word count arrives low byte first.
  function automatic count_t le_count(input logic [7:0] lo, input logic [7:0] hi);
    return {hi, lo};
  endfunction

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian 4-byte word assembler; word_valid fires combinationally with
// the 4th accepted byte so the parent can register the write strobe.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane_r;
  logic [23:0] shift_r;

  // Completion decode: the 4th byte is taken straight from the bus.
  always_comb begin
    word_valid = take && (lane_r == LAST_LANE);
    word       = {data, shift_r};
  end

  // Lane counter and storage for the first three bytes of a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_r  <= 2'd0;
      shift_r <= 24'd0;
    end else if (clear) begin
      lane_r  <= 2'd0;
      shift_r <= 24'd0;
    end else if (take) begin
      lane_r <= lane_r + 2'd1;
      case (lane_r)
        2'd0:    shift_r[7:0]   <= data;
        2'd1:    shift_r[15:8]  <= data;
        2'd2:    shift_r[23:16] <= data;
        default: shift_r        <= shift_r;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it into
// instruction memory. Trailing XOR checksum enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int SIZE = 1024,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic          i_clk,
  input  logic          in_rst,
  input  logic          i_start,
  input  logic          i_byte_valid,
  input  logic [7:0]    i_byte,
  output logic          o_byte_ready,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [31:0]   o_wdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam logic [16:0] SIZE_W    = 17'(SIZE);
  localparam logic        LEN_LAST  = 1'(LEN_BYTES - 1);

  state_t      state_r;
  logic [7:0]  n_lo_r;
  logic        len_cnt_r;
  count_t      n_r;
  count_t      wcnt_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_r;
`endif

  logic        take_s;
  logic        pack_take_s;
  logic        start_s;
  logic        word_valid_s;
  logic        last_word_s;
  logic [31:0] word_s;
  count_t      len_s;

  // Handshake and decode terms shared by the FSM and the packer.
  always_comb begin
    take_s      = i_byte_valid && o_byte_ready;
    pack_take_s = take_s && (state_r == S_DATA);
    start_s     = i_start && (state_r == S_IDLE);
    len_s       = le_count(n_lo_r, i_byte);
    last_word_s = ((wcnt_r + 16'd1) == n_r);
  end

  imem_byte_packer u_packer (
    .clk        (i_clk),
    .rst        (in_rst),
    .clear      (start_s),
    .take       (pack_take_s),
    .data       (i_byte),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk or posedge in_rst) begin
    if (in_rst) begin
      state_r      <= S_IDLE;
      o_we         <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_byte_ready <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= 32'd0;
      n_lo_r       <= 8'd0;
      len_cnt_r    <= 1'b0;
      n_r          <= 16'd0;
      wcnt_r       <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r       <= 8'd0;
`endif
    end else begin
      o_we   <= 1'b0;
      o_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            state_r      <= S_LEN;
            o_busy       <= 1'b1;
            o_byte_ready <= 1'b1;
            o_err        <= 1'b0;
            len_cnt_r    <= 1'b0;
            n_r          <= 16'd0;
            wcnt_r       <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r       <= 8'd0;
`endif
          end
        end
        S_LEN: begin
          if (take_s) begin
            if (len_cnt_r != LEN_LAST) begin
              n_lo_r    <= i_byte;
              len_cnt_r <= 1'b1;
            end else begin
              n_r <= len_s;
              if ({1'b0, len_s} > SIZE_W) begin
                // Oversize image: refuse it entirely rather than truncate.
                o_err        <= 1'b1;
                state_r      <= S_FIN;
                o_byte_ready <= 1'b0;
                o_done       <= 1'b1;
              end else if (len_s == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_r      <= S_CSUM;
`else
                state_r      <= S_FIN;
                o_byte_ready <= 1'b0;
                o_done       <= 1'b1;
`endif
              end else begin
                state_r <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (take_s) begin
            csum_r <= xor_fold(csum_r, i_byte);
          end
`endif
          if (word_valid_s) begin
            o_we    <= 1'b1;
            o_waddr <= wcnt_r[AW-1:0];
            o_wdata <= word_s;
            wcnt_r  <= wcnt_r + 16'd1;
            if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_r      <= S_CSUM;
`else
              state_r      <= S_FIN;
              o_byte_ready <= 1'b0;
              o_done       <= 1'b1;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (take_s) begin
            if (i_byte != csum_r) begin
              o_err <= 1'b1;
            end
            state_r      <= S_FIN;
            o_byte_ready <= 1'b0;
            o_done       <= 1'b1;
          end
        end
`endif
        S_FIN: begin
          state_r <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          state_r      <= S_IDLE;
          o_busy       <= 1'b0;
          o_byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; checksum scenarios run when
// IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int SIZE = 1024;
  localparam int AW   = 10;

  logic          i_clk;
  logic          in_rst;
  logic          i_start;
  logic          i_byte_valid;
  logic [7:0]    i_byte;
  logic          o_byte_ready;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [31:0]   o_wdata;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  imem_loader #(.SIZE(SIZE)) dut (
    .i_clk        (i_clk),
    .in_rst       (in_rst),
    .i_start      (i_start),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_we         (o_we),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Monitor: handshake counting on the active edge, output logging mid-cycle.
  int            cyc         = 0;
  int            hs_cnt      = 0;
  int            last_hs_cyc = -1;
  int            done_cnt    = 0;
  int            done_cyc    = 0;
  logic          done_err    = 1'b0;
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            wr_hs_q[$];
  int            wr_lag_q[$];

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (i_byte_valid && o_byte_ready && !in_rst) begin
      hs_cnt      <= hs_cnt + 1;
      last_hs_cyc <= cyc + 1;
    end
  end

  always @(negedge i_clk) begin
    if (o_we) begin
      wr_addr_q.push_back(o_waddr);
      wr_data_q.push_back(o_wdata);
      wr_hs_q.push_back(hs_cnt);
      wr_lag_q.push_back(cyc - last_hs_cyc);
    end
    if (o_done) begin
      done_cnt <= done_cnt + 1;
      done_err <= o_err;
      done_cyc <= cyc;
    end
  end

  logic [7:0]  basic_s[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
  logic [31:0] basic_w[2]  = '{32'h00100513, 32'h00200593};

  task automatic settle(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge i_clk);
      i_byte_valid = 1'b0;
    end
    @(negedge i_clk);
    i_byte_valid = 1'b1;
    i_byte       = b;
    t = 0;
    while (!o_byte_ready && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    vec_cnt++;
    if (!o_byte_ready) begin
      miss_cnt++;
      $display("FAIL send_byte ready: got %0b expected 1", o_byte_ready);
    end
  endtask

  task automatic idle_bus();
    @(negedge i_clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int t;
    t = 0;
    while (done_cnt == base && t < 40) begin
      @(negedge i_clk);
      #1;
      t++;
    end
    vec_cnt++;
    if (done_cnt == base) begin
      miss_cnt++;
      $display("FAIL done_timeout: got no o_done expected one pulse");
    end
  endtask

  task automatic test_reset();
    in_rst       = 1'b1;
    i_start      = 1'b0;
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
    settle(3);
    vec_cnt++;
    if ({o_we, o_busy, o_done, o_err, o_byte_ready} !== 5'b00000) begin
      miss_cnt++;
      $display("FAIL reset_flags: got %b expected 00000", {o_we, o_busy, o_done, o_err, o_byte_ready});
    end
    vec_cnt++;
    if (o_waddr !== 10'd0 || o_wdata !== 32'd0) begin
      miss_cnt++;
      $display("FAIL reset_bus: got %h/%h expected 000/00000000", o_waddr, o_wdata);
    end
    in_rst = 1'b0;
    settle(1);
    vec_cnt++;
    if (o_busy !== 1'b0 || o_byte_ready !== 1'b0) begin
      miss_cnt++;
      $display("FAIL idle_after_reset: got busy=%0b ready=%0b expected 0/0", o_busy, o_byte_ready);
    end
  endtask

  task automatic test_load(input string name, input int gap);
    int wb, db, hb, nw;
    wb = wr_addr_q.size();
    db = done_cnt;
    hb = hs_cnt;
    pulse_start();
    vec_cnt++;
    if (o_busy !== 1'b1) begin
      miss_cnt++;
      $display("FAIL %s busy: got %0b expected 1", name, o_busy);
    end
    for (int i = 0; i < 10; i++) begin
      // A start request mid-load must be ignored.
      if (gap > 0 && i == 4) i_start = 1'b1;
      if (i == 8) i_start = 1'b0;
      send_byte(basic_s[i], gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hB0, gap);
`endif
    idle_bus();
    wait_done(db);
    settle(2);
    nw = wr_addr_q.size() - wb;
    vec_cnt++;
    if (nw !== 2) begin
      miss_cnt++;
      $display("FAIL %s write_count: got %0d expected 2", name, nw);
    end
    for (int k = 0; k < 2; k++) begin
      if (wb + k < wr_addr_q.size()) begin
        vec_cnt++;
        if (wr_addr_q[wb+k] !== 10'(k) || wr_data_q[wb+k] !== basic_w[k]) begin
          miss_cnt++;
          $display("FAIL %s word%0d: got %h@%0d expected %h@%0d", name, k, wr_data_q[wb+k], wr_addr_q[wb+k], basic_w[k], k);
        end
        vec_cnt++;
        if (wr_hs_q[wb+k] - hb !== 2 + 4 * (k + 1) || wr_lag_q[wb+k] !== 0) begin
          miss_cnt++;
          $display("FAIL %s word%0d timing: got bytes=%0d lag=%0d expected bytes=%0d lag=0", name, k, wr_hs_q[wb+k] - hb, wr_lag_q[wb+k], 2 + 4 * (k + 1));
        end
      end
    end
    vec_cnt++;
    if (done_cnt - db !== 1 || done_err !== 1'b0) begin
      miss_cnt++;
      $display("FAIL %s done: got pulses=%0d err=%0b expected 1/0", name, done_cnt - db, done_err);
    end
    vec_cnt++;
    if (o_busy !== 1'b0 || o_err !== 1'b0) begin
      miss_cnt++;
      $display("FAIL %s final: got busy=%0b err=%0b expected 0/0", name, o_busy, o_err);
    end
  endtask

  task automatic test_zero_count();
    int wb, db;
    wb = wr_addr_q.size();
    db = done_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    idle_bus();
    wait_done(db);
    settle(2);
    vec_cnt++;
    if (wr_addr_q.size() !== wb) begin
      miss_cnt++;
      $display("FAIL zero_writes: got %0d expected 0", wr_addr_q.size() - wb);
    end
    vec_cnt++;
    if (done_cnt - db !== 1 || done_err !== 1'b0 || done_cyc - last_hs_cyc > 2) begin
      miss_cnt++;
      $display("FAIL zero_done: got pulses=%0d err=%0b delay=%0d expected 1/0/<=2", done_cnt - db, done_err, done_cyc - last_hs_cyc);
    end
  endtask

  task automatic test_oversize();
    int wb, db;
    wb = wr_addr_q.size();
    db = done_cnt;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    idle_bus();
    wait_done(db);
    settle(2);
    vec_cnt++;
    if (wr_addr_q.size() !== wb) begin
      miss_cnt++;
      $display("FAIL oversize_writes: got %0d expected 0", wr_addr_q.size() - wb);
    end
    vec_cnt++;
    if (done_err !== 1'b1 || o_err !== 1'b1 || o_byte_ready !== 1'b0) begin
      miss_cnt++;
      $display("FAIL oversize_err: got done_err=%0b err=%0b ready=%0b expected 1/1/0", done_err, o_err, o_byte_ready);
    end
    pulse_start();
    #1;
    vec_cnt++;
    if (o_err !== 1'b0 || o_busy !== 1'b1) begin
      miss_cnt++;
      $display("FAIL oversize_clear: got err=%0b busy=%0b expected 0/1", o_err, o_busy);
    end
    db = done_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    idle_bus();
    wait_done(db);
    settle(1);
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(basic_s[i], 0);
    idle_bus();
    #1;
    vec_cnt++;
    if (o_busy !== 1'b1 || o_wdata !== 32'h00100513) begin
      miss_cnt++;
      $display("FAIL midload_pre: got busy=%0b wdata=%h expected 1/00100513", o_busy, o_wdata);
    end
    in_rst = 1'b1;
    #1;
    vec_cnt++;
    if ({o_we, o_busy, o_done, o_err, o_byte_ready} !== 5'b00000 || o_waddr !== 10'd0 || o_wdata !== 32'd0) begin
      miss_cnt++;
      $display("FAIL midload_reset: got flags=%b addr=%h data=%h expected 00000/000/00000000",
               {o_we, o_busy, o_done, o_err, o_byte_ready}, o_waddr, o_wdata);
    end
    @(negedge i_clk);
    in_rst = 1'b0;
    test_load("after_reset", 0);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic [7:0] trailer, input logic exp_err);
    int wb, db;
    wb = wr_addr_q.size();
    db = done_cnt;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 2; i < 6; i++) send_byte(basic_s[i], 0);
    send_byte(trailer, 0);
    idle_bus();
    wait_done(db);
    settle(2);
    vec_cnt++;
    if (wr_addr_q.size() - wb !== 1 || wr_data_q[wr_data_q.size()-1] !== 32'h00100513) begin
      miss_cnt++;
      $display("FAIL csum_%h write: got count=%0d expected 1 of 00100513", trailer, wr_addr_q.size() - wb);
    end
    vec_cnt++;
    if (done_err !== exp_err || o_err !== exp_err) begin
      miss_cnt++;
      $display("FAIL csum_%h err: got %0b/%0b expected %0b", trailer, done_err, o_err, exp_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load("basic", 0);
    test_load("backpressure", 1);
    test_zero_count();
    test_oversize();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum(8'h06, 1'b0);
    test_checksum(8'h07, 1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
